// File: rtl/guess_game_n_if.sv
// Button/display bundle between the debounced button bank and the reaction game.
// master = button/display side, slave = game core.
interface guess_game_n_if #(
    parameter int N       = 4,
    parameter int SCORE_W = 8,
    parameter int LW      = 2
);
    logic [N-1:0]       b;
    logic [N-1:0]       y;
    logic               win;
    logic               lose;
    logic [SCORE_W-1:0] score;
    logic [LW-1:0]      lives_left;
    logic               game_over;

    modport master (
        output b,
        input  y, win, lose, score, lives_left, game_over
    );

    modport slave (
        input  b,
        output y, win, lose, score, lives_left, game_over
    );
endinterface

// File: rtl/guess_game_n.sv
// N-position reaction game: a one-hot light walks across N LEDs; matching presses score, wrong ones cost lives.
// Optional macro GUESS_SPEEDUP_EN shortens the step period on every hit (floored at TICK_DIV/4).
module guess_game_n #(
    parameter int N        = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter int LIVES    = 3,
    parameter int SCORE_W  = 8
) (
    input  logic           clk,
    input  logic           reset,
    guess_game_n_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(LIVES + 1);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] C_DIV = CW'(TICK_DIV);

    typedef enum logic [1:0] {S_RUN, S_WIN, S_MISS, S_OVER} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_pos, w_pos_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [LW-1:0]      r_lives, w_lives_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [CW-1:0]      w_period;
    logic [N-1:0]       w_y;
    logic               w_tick;
    logic               w_pressed;

`ifdef GUESS_SPEEDUP_EN
    localparam logic [CW-1:0] C_STEP  = CW'(TICK_DIV / 8);
    localparam logic [CW-1:0] C_FLOOR = CW'(TICK_DIV / 4);

    logic [CW-1:0] r_period, w_period_nxt;
    logic          w_hit;

    assign w_period = r_period;
    assign w_hit    = (r_state == S_RUN) && w_pressed && (bus.b == w_y);

    // Compare before subtracting so the floor clamp never sees an underflow.
    always_comb begin
        w_period_nxt = r_period;
        if (w_hit) begin
            if (r_period > (C_FLOOR + C_STEP)) w_period_nxt = r_period - C_STEP;
            else                               w_period_nxt = C_FLOOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_period <= C_DIV;
        else       r_period <= w_period_nxt;
    end
`else
    assign w_period = C_DIV;
`endif

    assign w_pressed = (bus.b != '0);
    assign w_y       = (r_state == S_RUN) ? ({{(N-1){1'b0}}, 1'b1} << r_pos) : '0;
    assign w_tick    = (r_state == S_RUN) && (r_cnt == (w_period - CW'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = '0;
        unique case (r_state)
            S_RUN: begin
                // A press outranks a same-cycle tick and is judged against the pre-step light.
                if (w_pressed) begin
                    if (bus.b == w_y) begin
                        w_state_nxt = S_WIN;
                        if (r_score != '1) w_score_nxt = r_score + SCORE_W'(1);
                    end else begin
                        w_state_nxt = S_MISS;
                        w_lives_nxt = r_lives - LW'(1);
                    end
                end else if (w_tick) begin
                    w_pos_nxt = (r_pos == PW'(N - 1)) ? '0 : r_pos + PW'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WIN: begin
                if (!w_pressed) begin
                    w_state_nxt = S_RUN;
                    w_pos_nxt   = '0;
                end
            end
            S_MISS: begin
                if (!w_pressed) begin
                    w_pos_nxt   = '0;
                    w_state_nxt = (r_lives == '0) ? S_OVER : S_RUN;
                end
            end
            S_OVER: w_state_nxt = S_OVER;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pos   <= '0;
            r_score <= '0;
            r_lives <= LW'(LIVES);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_score <= w_score_nxt;
            r_lives <= w_lives_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.y          = w_y;
    assign bus.win        = (r_state == S_WIN);
    assign bus.lose       = (r_state == S_MISS) || (r_state == S_OVER);
    assign bus.game_over  = (r_state == S_OVER);
    assign bus.score      = r_score;
    assign bus.lives_left = r_lives;
endmodule

// File: tb/tb_guess_game_n.sv
// Directed bench for guess_game_n with N=4, TICK_DIV=8, LIVES=2, SCORE_W=4.
module tb_guess_game_n;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;

    guess_game_n_if #(.N(4), .SCORE_W(4), .LW(2)) bus ();

    guess_game_n #(.N(4), .TICK_DIV(8), .LIVES(2), .SCORE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.b = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.b = '0;
        reset = 1'b1;
        #2;
        chk("rst_y_async", bus.y, 4'b0001);
        do_reset();
        chk("rst_y", bus.y, 4'b0001);
        chk("rst_win", bus.win, 1'b0);
        chk("rst_lose", bus.lose, 1'b0);
        chk("rst_score", bus.score, 4'd0);
        chk("rst_lives", bus.lives_left, 2'd2);
        chk("rst_over", bus.game_over, 1'b0);

        // 1: light walks with 8 clocks per position
        for (int i = 0; i < 40; i++) begin
            logic [3:0] exp_y;
            exp_y = 4'b0001 << ((i / 8) % 4);
            chk("walk_y", bus.y, exp_y);
            chk("walk_wl", {bus.win, bus.lose}, 2'b00);
            step();
        end

        // 2: hit on position 2, held for 3 clocks
        do_reset();
        repeat (16) step();
        chk("hit_pre_y", bus.y, 4'b0100);
        bus.b = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hit_win", bus.win, 1'b1);
            chk("hit_y", bus.y, 4'b0000);
            chk("hit_score", bus.score, 4'd1);
        end
        bus.b = '0;
        step();
        chk("hit_rel_y", bus.y, 4'b0001);
        chk("hit_rel_win", bus.win, 1'b0);

        // 3: two misses lead to an absorbing game over
        do_reset();
        bus.b = 4'b0010;
        step();
        chk("miss1_lose", bus.lose, 1'b1);
        chk("miss1_lives", bus.lives_left, 2'd1);
        chk("miss1_y", bus.y, 4'b0000);
        bus.b = '0;
        step();
        chk("miss1_rel_y", bus.y, 4'b0001);
        chk("miss1_rel_lose", bus.lose, 1'b0);
        bus.b = 4'b0010;
        step();
        chk("miss2_lives", bus.lives_left, 2'd0);
        chk("miss2_over", bus.game_over, 1'b0);
        bus.b = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("over_flags", {bus.game_over, bus.lose, bus.win}, 3'b110);
            chk("over_y", bus.y, 4'b0000);
        end

        // 4: multi-hot press counts as a miss
        do_reset();
        bus.b = 4'b0011;
        step();
        chk("multi_lose", bus.lose, 1'b1);
        chk("multi_lives", bus.lives_left, 2'd1);
        chk("multi_score", bus.score, 4'd0);
        bus.b = '0;
        step();

        // 5: press on the tick cycle is judged against the pre-step light
        do_reset();
        repeat (31) step();
        chk("tick_pre_y", bus.y, 4'b1000);
        bus.b = 4'b1000;
        step();
        chk("tick_win", bus.win, 1'b1);
        chk("tick_y", bus.y, 4'b0000);
        chk("tick_score", bus.score, 4'd1);
        chk("tick_lose", bus.lose, 1'b0);
        bus.b = '0;
        step();
        chk("tick_rel_y", bus.y, 4'b0001);

        // 6: score saturates at 15, then async reset in the middle of WIN
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            bus.b = 4'b0001;
            step();
            chk("sat_score", bus.score, (k > 15) ? 4'd15 : 4'(k));
            bus.b = '0;
            step();
        end
        bus.b = 4'b0001;
        step();
        chk("midwin_win", bus.win, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midwin_y", bus.y, 4'b0001);
        chk("midwin_score", bus.score, 4'd0);
        chk("midwin_lives", bus.lives_left, 2'd2);
        chk("midwin_win_clr", bus.win, 1'b0);
        bus.b = '0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_y", bus.y, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
